// File: rtl/dna_reader.sv
// Sequencer for the DNA_PORT serial interface: loads the device DNA, shifts it
// out MSB-first into dna_value, and raises dna_valid once the read is complete.
module dna_reader #(
  parameter int DW   = 57,
  parameter int DIV  = 4,
  parameter int AUTO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dna_dout,
  output logic          dna_clk,
  output logic          dna_read,
  output logic          dna_shift,
  output logic [DW-1:0] dna_value,
  output logic          dna_valid,
  output logic          busy
);

  localparam int BCW = $clog2(DW + 1);
  localparam int DCW = $clog2(DIV + 1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DW);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state;
  logic [DCW-1:0] div_cnt;
  logic [BCW-1:0] bit_cnt;

  // NOTE: every register here is assigned with <= so all of them update
  // together from the same pre-edge values; blocking assignments in a
  // clocked block would make later statements see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (AUTO != 0) ? LOAD : IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      dna_clk   <= 1'b0;
      dna_read  <= 1'b0;
      dna_shift <= 1'b0;
      // NOTE: dna_value is a datapath register but is published on the system
      // bus, so it is cleared on reset rather than left holding stale data.
      dna_value <= '0;
      dna_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            div_cnt   <= '0;
            dna_clk   <= 1'b0;
            dna_read  <= 1'b1;
            dna_valid <= 1'b0;
            busy      <= 1'b1;
          end
        end

        LOAD: begin
          if (!busy) begin
            // Arrived here straight from reset: arm outputs as a start would.
            dna_read <= 1'b1;
            busy     <= 1'b1;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (dna_clk) begin
              dna_clk   <= 1'b0;
              dna_read  <= 1'b0;
              dna_shift <= 1'b1;
              bit_cnt   <= '0;
              state     <= SHIFT;
            end else begin
              dna_clk <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end

        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!dna_clk) begin
              // Last clk of the low phase: capture the bit before the rising edge.
              dna_value <= {dna_value[DW-2:0], dna_dout};
              bit_cnt   <= bit_cnt + BCW'(1);
              dna_clk   <= 1'b1;
            end else begin
              dna_clk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                dna_shift <= 1'b0;
                dna_valid <= 1'b1;
                busy      <= 1'b0;
                state     <= DONE;
              end
            end
          end else begin
            div_cnt <= div_cnt + DCW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_reader.sv
// Bench for dna_reader: three instances (DIV=4 AUTO=1, DIV=4 AUTO=0, DIV=1 AUTO=1),
// each driving its own behavioural DNA_PORT model, checked against expected values.
module tb_dna_reader;

  localparam int DW = 57;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  rst, start, dna_clk, dna_read, dna_shift, dna_valid, busy;
  logic [DW-1:0] dna_value [N];
  logic [DW-1:0] dna_id    [N];

  int compared   = 0;
  int mismatched = 0;

  function automatic int div_of(input int idx);
    return (idx == 2) ? 1 : 4;
  endfunction

  function automatic logic [DW-1:0] rand_dna();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    // DNA_PORT model: READ loads the ID on a rising CLK, SHIFT moves it up one bit.
    logic [DW-1:0] shreg = '0;
    logic          dout;
    assign dout = shreg[DW-1];

    always @(posedge dna_clk[g]) begin
      if (dna_read[g])       shreg <= dna_id[g];
      else if (dna_shift[g]) shreg <= {shreg[DW-2:0], 1'b0};
    end

    dna_reader #(.DW(DW), .DIV(g == 2 ? 1 : 4), .AUTO(g == 1 ? 0 : 1)) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .start    (start[g]),
      .dna_dout (dout),
      .dna_clk  (dna_clk[g]),
      .dna_read (dna_read[g]),
      .dna_shift(dna_shift[g]),
      .dna_value(dna_value[g]),
      .dna_valid(dna_valid[g]),
      .busy     (busy[g])
    );
  end

  // Caller has just triggered a read (start or rst release) at a negedge.
  // Watches the whole sequence, optionally pokes start mid-read.
  task automatic wait_done(input int idx, input logic [DW-1:0] exp_val,
                           input int poke_at, input bit chk_proto, input string name);
    int   lat, k, got, rd, rd_rise, sh_rise, both;
    logic prev;
    lat = 2 * div_of(idx) * (DW + 1) + 1;
    k = 0; got = -1; rd = 0; rd_rise = 0; sh_rise = 0; both = 0;
    prev = dna_clk[idx];
    while (got < 0 && k < lat + 100) begin
      @(negedge clk);
      k++;
      start[idx] = (k == poke_at);
      if (k == 1) begin
        compared++;
        if ({busy[idx], dna_valid[idx]} !== 2'b10) begin
          mismatched++;
          $display("FAIL %s first_cycle: busy,valid=%b expected 10", name,
                   {busy[idx], dna_valid[idx]});
        end
      end
      if (dna_read[idx] === 1'b1) rd++;
      if (dna_clk[idx] === 1'b1 && prev === 1'b0) begin
        if (dna_read[idx] === 1'b1)  rd_rise++;
        if (dna_shift[idx] === 1'b1) sh_rise++;
      end
      if (dna_read[idx] === 1'b1 && dna_shift[idx] === 1'b1) both++;
      prev = dna_clk[idx];
      if (dna_valid[idx] === 1'b1) got = k;
    end
    start[idx] = 1'b0;

    compared++;
    if (got !== lat) begin
      mismatched++;
      $display("FAIL %s latency: got %0d expected %0d", name, got, lat);
    end
    compared++;
    if (dna_value[idx] !== exp_val) begin
      mismatched++;
      $display("FAIL %s value: got %h expected %h", name, dna_value[idx], exp_val);
    end
    compared++;
    if ({busy[idx], dna_shift[idx], dna_clk[idx], dna_read[idx]} !== 4'b0000) begin
      mismatched++;
      $display("FAIL %s done_outputs: busy,shift,clk,read=%b expected 0000", name,
               {busy[idx], dna_shift[idx], dna_clk[idx], dna_read[idx]});
    end
    if (chk_proto) begin
      compared++;
      if (rd !== 2 * div_of(idx)) begin
        mismatched++;
        $display("FAIL %s read_cycles: got %0d expected %0d", name, rd, 2 * div_of(idx));
      end
      compared++;
      if (rd_rise !== 1) begin
        mismatched++;
        $display("FAIL %s read_rises: got %0d expected 1", name, rd_rise);
      end
      compared++;
      if (sh_rise !== DW) begin
        mismatched++;
        $display("FAIL %s shift_rises: got %0d expected %0d", name, sh_rise, DW);
      end
      compared++;
      if (both !== 0) begin
        mismatched++;
        $display("FAIL %s read_shift_overlap: got %0d cycles expected 0", name, both);
      end
    end
  endtask

  task automatic check_zero(input int idx, input string name);
    compared++;
    if ({dna_clk[idx], dna_read[idx], dna_shift[idx], dna_valid[idx], busy[idx]} !== 5'b0 ||
        dna_value[idx] !== '0) begin
      mismatched++;
      $display("FAIL %s outputs: clk,read,shift,valid,busy=%b value=%h expected all 0", name,
               {dna_clk[idx], dna_read[idx], dna_shift[idx], dna_valid[idx], busy[idx]},
               dna_value[idx]);
    end
  endtask

  task automatic test_reset();
    rst = '1; start = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) check_zero(i, $sformatf("reset_%0d", i));
    // start coincident with rst must be ignored
    start = '1;
    @(negedge clk);
    start = '0;
    for (int i = 0; i < N; i++) check_zero(i, $sformatf("reset_start_%0d", i));
  endtask

  task automatic test_auto_read();
    rst[0] = 1'b0;
    wait_done(0, dna_id[0], 0, 1'b1, "auto_read");
  endtask

  task automatic test_auto0_idle();
    int bad;
    bad = 0;
    rst[1] = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if ({dna_clk[1], dna_read[1], dna_shift[1], dna_valid[1], busy[1]} !== 5'b0 ||
          dna_value[1] !== '0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL auto0_idle: %0d active cycles expected 0", bad);
    end
    start[1] = 1'b1;
    wait_done(1, dna_id[1], 0, 1'b1, "auto0_start");
  endtask

  task automatic test_reread();
    dna_id[0] = 57'h1FFFFFFFFFFFFFF;
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, dna_id[0], 0, 1'b1, "reread_ones");
    for (int n = 0; n < 3; n++) begin
      dna_id[1] = rand_dna();
      repeat ($urandom_range(1, 20)) @(negedge clk);
      start[1] = 1'b1;
      wait_done(1, dna_id[1], 0, 1'b0, $sformatf("reread_rand_%0d", n));
    end
  endtask

  task automatic test_busy_start();
    dna_id[0] = rand_dna();
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, dna_id[0], 100, 1'b1, "busy_start_100");
    dna_id[0] = rand_dna();
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, dna_id[0], $urandom_range(2, 460), 1'b0, "busy_start_rand");
  endtask

  task automatic test_reset_abort(input int idx, input int at, input string name);
    dna_id[idx] = rand_dna();
    @(negedge clk);
    start[idx] = 1'b1;
    @(negedge clk);
    start[idx] = 1'b0;
    repeat (at - 1) @(negedge clk);
    rst[idx] = 1'b1;
    @(negedge clk);
    check_zero(idx, {name, "_zero"});
    rst[idx] = 1'b0;
    dna_id[idx] = rand_dna();
    wait_done(idx, dna_id[idx], 0, 1'b1, name);
  endtask

  task automatic test_div1();
    rst[2] = 1'b0;
    wait_done(2, dna_id[2], 0, 1'b1, "div1_auto");
    test_reset_abort(2, 50, "div1_abort");
  endtask

  initial begin
    dna_id[0] = 57'h0823456789ABCDE;
    dna_id[1] = rand_dna();
    dna_id[2] = rand_dna();
    test_reset();
    test_auto_read();
    test_auto0_idle();
    test_reread();
    test_busy_start();
    test_reset_abort(0, 200, "abort_200");
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
